// File: rtl/led_array_scanner_if.sv
// Frame-load and LED drive signals of the LED array scanner.
interface led_array_scanner_if #(
  parameter int N = 5
);
  logic           ena;
  logic           load;
  logic [N*N-1:0] cells_in;
  logic [N-1:0]   rows;
  logic [N-1:0]   cols;
  logic           frame_done;

  modport master (output ena, load, cells_in, input rows, cols, frame_done);
  modport slave  (input ena, load, cells_in, output rows, cols, frame_done);
endinterface

// File: rtl/led_array_scanner.sv
// Column-multiplexed N x N LED array scanner with a double-buffered frame
// that only swaps at a frame boundary, so a displayed frame is never torn.
module led_array_scanner #(
  parameter int N     = 5,
  parameter int DWELL = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  led_array_scanner_if.slave    bus
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("led_array_scanner: N must be in 2..8");
  end
  if (DWELL < 1) begin : g_bad_dwell
    $error("led_array_scanner: DWELL must be >= 1");
  end

  localparam int XW = $clog2(N);
  localparam int DW = $clog2(DWELL) + 1;
  localparam logic [XW-1:0] XLAST = XW'(N - 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [N*N-1:0] display_q, display_d;
  logic [N*N-1:0] shadow_q, shadow_d;
  logic           pending_q, pending_d;
  logic [N-1:0]   lit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      dwell_q   <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      dwell_q   <= dwell_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    dwell_d   = dwell_q;
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        // Nothing is being shown mid-frame, so a new frame goes straight in.
        if (bus.load) begin
          display_d = bus.cells_in;
          pending_d = 1'b0;
        end
        if (bus.ena) begin
          state_d = SCAN;
          x_d     = '0;
          dwell_d = '0;
        end
      end
      default: begin
        if (bus.load) begin
          shadow_d  = bus.cells_in;
          pending_d = 1'b1;
        end
        if (!bus.ena) begin
          state_d = IDLE;
          x_d     = '0;
          dwell_d = '0;
        end else if (state_q == SCAN) begin
          if (dwell_q == DLAST) begin
            state_d = BLANK;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end else begin
          state_d = SCAN;
          if (x_q == XLAST) begin
            // Frame boundary: a same-cycle load wins over the older pending frame.
            x_d = '0;
            if (bus.load) begin
              display_d = bus.cells_in;
              pending_d = 1'b0;
            end else if (pending_q) begin
              display_d = shadow_q;
              pending_d = 1'b0;
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
    endcase
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [N-1:0] row_cells;
    assign row_cells = display_q[r*N +: N];
    assign lit[r]    = row_cells[x_q];
  end

  always_comb begin
    bus.rows = '1;
    bus.cols = '0;
    if (state_q == SCAN) begin
      bus.rows = ~lit;
      bus.cols = N'(1) << x_q;
    end
    bus.frame_done = (state_q == BLANK) && (x_q == XLAST);
  end

endmodule

// File: doc/led_array_scanner.md
LED_ARRAY_SCANNER -- requirements
Module: led_array_scanner

Interface
REQ-001 SHALL have parameter N, default 5: grid size; legal range 2..8, elaboration error ($error) otherwise.
REQ-002 SHALL have parameter DWELL, default 1000: clock cycles each column is lit; legal range >= 1, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ena  input  1  scan enable; 0 blanks the array.
REQ-006 SHALL have port cells_in  input  N*N  new frame; cell (row r, col c) is bit r*N+c; 1 = lit.
REQ-007 SHALL have port load  input  1  single-cycle strobe; captures cells_in.
REQ-008 SHALL have port rows  output  N  row drive, active-low.
REQ-009 SHALL have port cols  output  N  column drive, one-hot, active-high.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-011 SHALL hold a display buffer (N*N), a shadow buffer (N*N), a pending flag, a column index x ($clog2(N) bits), a dwell counter ($clog2(DWELL)+1 bits), and FSM state IDLE/SCAN/BLANK.
REQ-012 SHALL decode rows/cols combinationally from registered state only, with no added latency.
REQ-013 SHALL in SCAN drive cols = one-hot(x) and rows[r] = ~display[r*N+x].
REQ-014 SHALL in IDLE and BLANK drive cols = 0 and rows = all 1s.
REQ-015 SHALL transition IDLE->SCAN when ena=1, with x=0 and dwell=0.
REQ-016 SHALL in SCAN increment dwell each cycle; at dwell=DWELL-1 go to BLANK and clear dwell.
REQ-017 SHALL stay in BLANK exactly 1 cycle, then return to SCAN with x+1; if x=N-1, x wraps to 0.
REQ-018 SHALL assert frame_done for the single BLANK cycle that follows column N-1; frame period = N*(DWELL+1) cycles.
REQ-019 SHALL in SCAN/BLANK on load copy cells_in to shadow and set pending.
REQ-020 SHALL on the BLANK->SCAN edge that wraps x to 0 with pending=1 copy shadow to display and clear pending; a frame is never torn.
REQ-021 SHALL, when load coincides with that swap edge, write cells_in directly to display and leave pending=0.
REQ-022 SHALL with multiple loads before a swap keep only the last cells_in.
REQ-023 SHALL in IDLE on load write cells_in directly to display and leave pending=0.
REQ-024 SHALL on ena=0 in SCAN/BLANK go to IDLE next edge, clear x and dwell, keep display/shadow/pending, no frame_done.
REQ-025 SHALL on ena re-assert restart at column 0 with full dwell.
REQ-026 SHALL ignore load while rst=1.

Reset
REQ-027 SHALL on rst=1, immediately and independent of clk: state=IDLE, x=0, dwell=0, display=0, shadow=0, pending=0.
REQ-028 SHALL during and after reset (until ena) drive rows=all 1s, cols=0, frame_done=0.
REQ-029 SHALL with reset asserted mid-scan blank outputs within the same cycle and discard any pending frame.

Verification (N=5, DWELL=4)
REQ-030 SHALL cover: rst=1 -> rows=5'b11111, cols=5'b00000, frame_done=0 with clk stopped.
REQ-031 SHALL cover: IDLE, load cells_in=25'h0000001, then ena=1 -> 4 cycles cols=00001 rows=11110; 1 cycle cols=0 rows=11111; then cols=00010 rows=11111.
REQ-032 SHALL cover: ena held 100 cycles -> frame_done pulses exactly every 25 cycles, one cycle wide, after column 4.
REQ-033 SHALL cover: display=0, load 25'h1FFFFFF while x=2 -> columns 2-4 rows=11111; from next column 0, rows=00000 for every column.
REQ-034 SHALL cover: ena=0 during column 3 dwell -> next cycle cols=0 rows=11111; ena=1 -> column 0 lit for 4 full cycles.
REQ-035 SHALL cover: load on the wrap edge with a different frame already pending -> the wrap-edge cells_in is displayed, pending=0.
